// File: rtl/maxpool2x2_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : maxpool2x2_stream                                            |
// | Description : 2x2 stride-2 pooling over a raster-ordered signed stream.    |
// |               Define POOL_AVG_EN to select average pooling instead of max. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module maxpool2x2_stream #(
    parameter int DW = 16,
    parameter int W  = 218,
    parameter int H  = 218,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din_pool,
    input  logic          din_valid,
    output logic [DW-1:0] dout_pool,
    output logic          valid,
    output logic          frame_done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int PW = W / 2;
`ifdef POOL_AVG_EN
    localparam int LBW = DW + 1;
`else
    localparam int LBW = DW;
`endif

    localparam logic [CW-1:0] c_COL_MAX  = CW'(W - 1);
    localparam logic [RW-1:0] c_ROW_MAX  = RW'(H - 1);
    localparam logic [CW-1:0] c_LAST_COL = CW'(2 * PW - 1);
    localparam logic [RW-1:0] c_LAST_ROW = RW'(2 * (H / 2) - 1);

    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic [DW-1:0]  r_hreg;
    logic [LBW-1:0] r_linebuf [0:PW-1];

    logic [AW-1:0]  w_addr;
    logic [LBW-1:0] w_lb;
    logic [LBW-1:0] w_pair;
    logic [DW-1:0]  w_pool;
    logic           w_in_pair;
    logic           w_last_col;
    logic           w_last_row;

    // With an odd width the trailing column never belongs to a window.
    assign w_in_pair  = ((W % 2) == 0) || (r_col != c_COL_MAX);
    assign w_addr     = AW'(r_col >> 1);
    assign w_lb       = r_linebuf[w_addr];
    assign w_last_col = (r_col == c_COL_MAX);
    assign w_last_row = (r_row == c_ROW_MAX);

`ifdef POOL_AVG_EN
    logic [DW+1:0] w_sum;
    assign w_pair = {r_hreg[DW-1], r_hreg} + {din_pool[DW-1], din_pool};
    assign w_sum  = {w_lb[DW], w_lb} + {w_pair[DW], w_pair};
    assign w_pool = w_sum[DW+1:2];
`else
    assign w_pair = ($signed(din_pool) > $signed(r_hreg)) ? din_pool : r_hreg;
    assign w_pool = ($signed(w_lb) > $signed(w_pair)) ? w_lb : w_pair;
`endif

    always_ff @(posedge clk) begin
        if (!rst && din_valid && w_in_pair && r_col[0] && !r_row[0]) begin
            r_linebuf[w_addr] <= w_pair;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_hreg     <= '0;
            dout_pool  <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            if (din_valid) begin
                if (w_in_pair) begin
                    if (!r_col[0]) begin
                        r_hreg <= din_pool;
                    end else if (r_row[0]) begin
                        dout_pool  <= w_pool;
                        valid      <= 1'b1;
                        frame_done <= (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
                    end
                end
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
